// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, width defaults and helpers for the UART TX arbiter
package uart_pkg;
   localparam int DEF_DATA_W = 8;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter: rotating-priority picker, first set req bit at or after ptr
module rr_arbiter import uart_pkg::*; #(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_nxt,
   output logic [IW-1:0] idx
);
   logic [N-1:0]   low_mask;
   logic [2*N-1:0] masked, first;
   // lower half keeps requests at/after ptr, upper half supplies the wrapped ones
   assign low_mask  = ~((N'(1) << ptr) - N'(1));
   assign masked    = {req, req & low_mask};
   assign first     = masked & (~masked + (2*N)'(1));
   assign grant_nxt = first[N-1:0] | first[2*N-1:N];
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) if (grant_nxt[i]) idx = IW'(i);
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX core, with a frame watchdog
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLKS_PER_BIT = 5208,
   parameter int TIMEOUT_CYC  = 12 * CLKS_PER_BIT,
   localparam int IW          = clog2(N_REQ),
   localparam int WD_W        = clog2(TIMEOUT_CYC + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic                    tx_start,
   output logic [DATA_W-1:0]       tx_data_in,
   input  logic                    tx_busy,
   input  logic                    tx_done,
   output logic                    arb_busy,
   output logic [IW-1:0]           owner,
   output logic                    timeout
);
   arb_state_t       state, state_nxt;
   logic [IW-1:0]    ptr, win_idx;
   logic [N_REQ-1:0] win_oh;
   logic [WD_W-1:0]  wd;
   logic             take, expire;

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
      .req       (req),
      .ptr       (ptr),
      .grant_nxt (win_oh),
      .idx       (win_idx)
   );

   assign take     = state == IDLE && req != '0 && !tx_busy;
   // a completion in the expiry cycle takes precedence over the abort
   assign expire   = state == WAIT_DONE && !tx_done && wd == WD_W'(TIMEOUT_CYC - 1);
   assign arb_busy = state != IDLE;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = take ? START : IDLE;
         START:     state_nxt = WAIT_DONE;
         WAIT_DONE: state_nxt = (tx_done || expire) ? IDLE : WAIT_DONE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         wd         <= '0;
         grant      <= '0;
         tx_start   <= 1'b0;
         timeout    <= 1'b0;
         tx_data_in <= '0;
         owner      <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= take ? win_oh : '0;
         tx_start <= state == START;
         timeout  <= expire;
         if (take) begin
            tx_data_in <= req_data[win_idx*DATA_W +: DATA_W];
            owner      <= win_idx;
            ptr        <= win_idx == IW'(N_REQ - 1) ? '0 : win_idx + 1'b1;
         end
         wd <= state == START ? '0 :
               (state == WAIT_DONE && wd != WD_W'(TIMEOUT_CYC)) ? wd + 1'b1 : wd;
      end
endmodule
